// File: rtl/hazard_sequencer.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline: load-use stalls,
// branch/jump flushes, multi-cycle mul freeze and a saturating stall counter.
module hazard_sequencer #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_Uses_Rs,
  input  logic             ID_Uses_Rt,
  input  logic             ID_Is_Mul,
  input  logic             ID_Jump,
  input  logic             EX_Mem_Read,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_Branch_Taken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             Control,
  output logic             IF_ID_Flush,
  output logic             EX_MEM_Bubble,
  output logic             Mul_Busy,
  output logic [CNT_W-1:0] Stall_Cycles
);

  localparam int unsigned MC_W = 4;
  localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_LATENCY - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [MC_W-1:0] mul_count;
  logic [MC_W-1:0] mul_count_nxt;
  logic            load_use;

  // A load in EX writing a register the ID instruction reads (r0 never hazards).
  assign load_use = EX_Mem_Read && (EX_Rd != 5'd0) &&
                    ((ID_Uses_Rs && (ID_Rs == EX_Rd)) ||
                     (ID_Uses_Rt && (ID_Rt == EX_Rd)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      mul_count <= '0;
    end else begin
      state     <= state_nxt;
      mul_count <= mul_count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mul_count_nxt = mul_count;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    Control       = 1'b0;
    IF_ID_Flush   = 1'b0;
    EX_MEM_Bubble = 1'b0;
    Mul_Busy      = 1'b0;

    unique case (state)
      IDLE: begin
        if (EX_Branch_Taken) begin
          IF_ID_Flush = 1'b1;
          Control     = 1'b1;
        end else if (load_use) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          Control     = 1'b1;
        end else if (ID_Jump) begin
          IF_ID_Flush = 1'b1;
        end else if (ID_Is_Mul && (MUL_LATENCY > 1)) begin
          state_nxt     = MUL_BUSY;
          mul_count_nxt = MUL_LOAD;
        end
      end
      MUL_BUSY: begin
        PC_Write      = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Write   = 1'b0;
        EX_MEM_Bubble = 1'b1;
        Mul_Busy      = 1'b1;
        // Count of 1 is the last frozen cycle; <=1 also recovers from a stray 0.
        if (mul_count <= MC_W'(1)) begin
          state_nxt     = IDLE;
          mul_count_nxt = '0;
        end else begin
          mul_count_nxt = mul_count - MC_W'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        mul_count_nxt = '0;
      end
    endcase

    if (Reset) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      Control       = 1'b1;
      IF_ID_Flush   = 1'b1;
      EX_MEM_Bubble = 1'b1;
      Mul_Busy      = 1'b0;
    end
  end

  // Saturating count of frozen-PC cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Stall_Cycles <= '0;
    end else if (!PC_Write && (Stall_Cycles != {CNT_W{1'b1}})) begin
      Stall_Cycles <= Stall_Cycles + CNT_W'(1);
    end
  end

endmodule
